sfp_acc_pipe: RTL and testbench

//   Pipelined, parametrised special-function processor between the OFIFO / PSUM memory and the

---
 rtl/sfp_acc_pipe.sv | 124 ++++++++++++
 tb/tb_sfp_acc_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_acc_pipe.sv
// Two-stage special-function pipeline: saturating PSUM accumulate (S1), then optional
// ReLU plus arithmetic right shift (S2), with valid/ready flow control and a tile-last marker.
module sfp_acc_pipe #(
  parameter int BW  = 16,
  parameter int COL = 8,
  parameter int SW  = 4,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [BW*COL-1:0] in_i,
  input  logic [BW*COL-1:0] in_pmem_i,
  input  logic              en_relu_i,
  input  logic [SW-1:0]     shift_i,
  input  logic [CW-1:0]     len_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BW*COL-1:0] out_o,
  output logic [COL-1:0]    out_sat_o,
  output logic              out_last_o
);

  logic                  stall;
  logic                  emit;

  logic                  s1_valid_q;
  logic [BW*COL-1:0]     s1_sum_q, s1_sum_d;
  logic [COL-1:0]        s1_sat_q, s1_sat_d;
  logic                  s1_relu_q;
  logic [SW-1:0]         s1_shift_q;
  logic [COL-1:0][BW:0]  wide_sum;

  logic                  out_valid_q;
  logic [BW*COL-1:0]     out_q, out_d;
  logic [COL-1:0]        out_sat_q;
  logic                  out_last_q, out_last_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         len_m1;

  // The whole pipeline freezes while the held output is refused downstream.
  assign stall      = out_valid_q & ~out_ready_i;
  assign emit       = out_valid_q & out_ready_i;
  assign in_ready_o = ~stall;

  // len=0 wraps to all-ones, which is exactly 2^CW-1.
  assign len_m1 = len_i - CW'(1);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    wide_sum = '0;
    s1_sum_d = '0;
    s1_sat_d = '0;
    for (int c = 0; c < COL; c++) begin
      wide_sum[c] = {in_i[BW*c+BW-1], in_i[BW*c +: BW]}
                  + {in_pmem_i[BW*c+BW-1], in_pmem_i[BW*c +: BW]};
      // Overflow shows as the two top bits of the BW+1 bit sum disagreeing.
      s1_sat_d[c] = wide_sum[c][BW] ^ wide_sum[c][BW-1];
      s1_sum_d[BW*c +: BW] = s1_sat_d[c] ? {wide_sum[c][BW], {(BW-1){~wide_sum[c][BW]}}}
                                         : wide_sum[c][BW-1:0];
    end
  end

  always_comb begin
    out_d = '0;
    for (int c = 0; c < COL; c++) begin
      if (!s1_relu_q)
        out_d[BW*c +: BW] = s1_sum_q[BW*c +: BW];
      else if (s1_sum_q[BW*c+BW-1])
        out_d[BW*c +: BW] = '0;
      else
        out_d[BW*c +: BW] = s1_sum_q[BW*c +: BW] >> s1_shift_q;
    end
  end

  // The word entering S2 is numbered after the one leaving it in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (emit)
      cnt_d = (cnt_q == len_m1) ? '0 : cnt_q + CW'(1);
    out_last_d = (cnt_d == len_m1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_sat_q    <= '0;
      s1_relu_q   <= 1'b0;
      s1_shift_q  <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sat_q   <= '0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!stall) begin
        s1_valid_q  <= in_valid_i;
        out_valid_q <= s1_valid_q;
        if (in_valid_i) begin
          s1_sum_q   <= s1_sum_d;
          s1_sat_q   <= s1_sat_d;
          s1_relu_q  <= en_relu_i;
          s1_shift_q <= shift_i;
        end
        if (s1_valid_q) begin
          out_q      <= out_d;
          out_sat_q  <= s1_sat_q;
          out_last_q <= out_last_d;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign out_sat_o   = out_sat_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_sfp_acc_pipe.sv
// Directed bench for sfp_acc_pipe: table of single-word vectors, then streaming sequences
// covering backpressure, tile-last marking and reset with words in flight.
module tb_sfp_acc_pipe;
  localparam int BW  = 16;
  localparam int COL = 8;
  localparam int SW  = 4;
  localparam int CW  = 8;
  localparam int W   = BW * COL;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_w;
  logic [W-1:0]   pmem_w;
  logic           en_relu;
  logic [SW-1:0]  shift;
  logic [CW-1:0]  len;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_w;
  logic [COL-1:0] out_sat;
  logic           out_last;

  int n_cmp  = 0;
  int n_err  = 0;
  int tb_cnt = 0;
  int tb_len = 256;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           relu;
    logic [SW-1:0]  sh;
    logic [W-1:0]   exp_out;
    logic [COL-1:0] exp_sat;
  } vec_t;

  vec_t vecs[9];

  sfp_acc_pipe #(.BW(BW), .COL(COL), .SW(SW), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_i        (in_w),
    .in_pmem_i   (pmem_w),
    .en_relu_i   (en_relu),
    .shift_i     (shift),
    .len_i       (len),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_o       (out_w),
    .out_sat_o   (out_sat),
    .out_last_o  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rep(input logic [BW-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[BW*c +: BW] = v;
    return r;
  endfunction

  // Stream word k: column c carries k*16+c+1 from OFIFO and k from PMEM.
  function automatic logic [W-1:0] stream_a(input int k);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[BW*c +: BW] = BW'(k * 16 + c + 1);
    return r;
  endfunction

  function automatic logic [W-1:0] stream_sum(input int k);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[BW*c +: BW] = BW'(k * 17 + c + 1);
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    tb_cnt = 0;
  endtask

  task automatic run_stream(input string tag, input int n, input int st_lo, input int st_hi);
    logic [W-1:0] expq[$];
    logic [W-1:0] e;
    logic         exp_last;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    en_relu = 1'b0;
    shift   = '0;
    while (got < n && cyc < 100) begin
      out_ready = !(cyc >= st_lo && cyc <= st_hi);
      in_valid  = (sent < n);
      in_w      = stream_a(sent);
      pmem_w    = rep(BW'(sent));
      #1;
      if (out_valid && !out_ready)
        check($sformatf("%s_in_ready_stall_c%0d", tag, cyc), W'(in_ready), W'(1'b0));
      if (out_valid && out_ready) begin
        e = expq.size() > 0 ? expq.pop_front() : '1;
        exp_last = (tb_cnt == tb_len - 1);
        check($sformatf("%s_out%0d", tag, got + 1), out_w, e);
        check($sformatf("%s_last%0d", tag, got + 1), W'(out_last), W'(exp_last));
        tb_cnt = exp_last ? 0 : tb_cnt + 1;
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(stream_sum(sent));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check($sformatf("%s_count", tag), W'(got), W'(n));
    step();
    step();
    check($sformatf("%s_drained", tag), W'(out_valid), W'(1'b0));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_w      = '0;
    pmem_w    = '0;
    en_relu   = 1'b0;
    shift     = '0;
    len       = '0;
    out_ready = 1'b1;

    // Vector table: single words through an otherwise idle pipe.
    vecs[0] = '{rep(16'd100), rep(16'hFFE2), 1'b0, 4'd0, rep(16'd70), 8'h00};
    vecs[1] = '{'0, '0, 1'b1, 4'd1, '0, 8'h00};
    for (int c = 0; c < COL; c++) begin
      vecs[1].a[BW*c +: BW]       = (c % 2 == 0) ? 16'hFFFB : 16'd40;
      vecs[1].exp_out[BW*c +: BW] = (c % 2 == 0) ? 16'd0 : 16'd20;
    end
    vecs[2] = '{rep(16'd25), rep(16'd15), 1'b1, 4'd3, rep(16'd5), 8'h00};
    vecs[3] = '{rep(16'd1), rep(16'd2), 1'b0, 4'd0, rep(16'd3), 8'h03};
    vecs[3].a[BW*0 +: BW] = 16'h7FF0; vecs[3].b[BW*0 +: BW] = 16'h0020;
    vecs[3].exp_out[BW*0 +: BW] = 16'h7FFF;
    vecs[3].a[BW*1 +: BW] = 16'h8000; vecs[3].b[BW*1 +: BW] = 16'hFFFF;
    vecs[3].exp_out[BW*1 +: BW] = 16'h8000;
    vecs[4] = '{rep(16'h1000), rep(16'h0100), 1'b1, 4'd4, rep(16'h0110), 8'h03};
    vecs[4].a[BW*0 +: BW] = 16'h7FF0; vecs[4].b[BW*0 +: BW] = 16'h0020;
    vecs[4].exp_out[BW*0 +: BW] = 16'h07FF;
    vecs[4].a[BW*1 +: BW] = 16'h8000; vecs[4].b[BW*1 +: BW] = 16'hFFFF;
    vecs[4].exp_out[BW*1 +: BW] = 16'h0000;
    vecs[5] = '{rep(16'h4000), rep(16'h4000), 1'b0, 4'd0, rep(16'h7FFF), 8'hFB};
    vecs[5].a[BW*2 +: BW] = 16'hC000; vecs[5].b[BW*2 +: BW] = 16'hC000;
    vecs[5].exp_out[BW*2 +: BW] = 16'h8000;
    vecs[5].a[BW*3 +: BW] = 16'h8000; vecs[5].b[BW*3 +: BW] = 16'h8000;
    vecs[5].exp_out[BW*3 +: BW] = 16'h8000;
    vecs[6] = '{rep(16'h7FFF), rep(16'h0000), 1'b1, 4'd15, rep(16'h0000), 8'h00};
    vecs[7] = '{rep(16'h04D2), rep(16'h0000), 1'b1, 4'd0, rep(16'h04D2), 8'h00};
    vecs[7].a[BW*5 +: BW] = 16'hFFFF;
    vecs[7].exp_out[BW*5 +: BW] = 16'h0000;
    vecs[7].a[BW*6 +: BW] = 16'h0000;
    vecs[7].exp_out[BW*6 +: BW] = 16'h0000;
    vecs[8] = '{rep(16'hFF38), rep(16'h0064), 1'b0, 4'd2, rep(16'hFF9C), 8'h00};

    step();
    step();
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_out", out_w, '0);
    check("rst_out_sat", W'(out_sat), '0);
    check("rst_out_last", W'(out_last), W'(1'b0));
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      in_w     = vecs[i].a;
      pmem_w   = vecs[i].b;
      en_relu  = vecs[i].relu;
      shift    = vecs[i].sh;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat1_valid", i), W'(out_valid), W'(1'b0));
      step();
      check($sformatf("vec%0d_valid", i), W'(out_valid), W'(1'b1));
      check($sformatf("vec%0d_out", i), out_w, vecs[i].exp_out);
      check($sformatf("vec%0d_sat", i), W'(out_sat), W'(vecs[i].exp_sat));
      step();
      check($sformatf("vec%0d_drop", i), W'(out_valid), W'(1'b0));
      check($sformatf("vec%0d_hold", i), out_w, vecs[i].exp_out);
    end

    // Backpressure: six back-to-back words, downstream refuses in cycles 3..5.
    do_reset();
    len = '0;
    tb_len = 256;
    run_stream("bp", 6, 3, 5);

    // Tile marking: len=4 over twelve words, last on 4, 8 and 12.
    do_reset();
    len = 8'd4;
    tb_len = 4;
    run_stream("len4", 12, -1, -1);

    // Reset with two words in flight, then a fresh len=3 tile.
    do_reset();
    len = 8'd3;
    tb_len = 3;
    en_relu = 1'b0;
    shift = '0;
    in_w = rep(16'h0123);
    pmem_w = '0;
    in_valid = 1'b1;
    step();
    in_w = rep(16'h0456);
    step();
    in_valid = 1'b0;
    check("inflight_valid", W'(out_valid), W'(1'b1));
    reset = 1'b1;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(1'b0));
    check("midrst_out", out_w, '0);
    check("midrst_out_sat", W'(out_sat), '0);
    step();
    reset = 1'b0;
    tb_cnt = 0;
    step();
    check("postrst_valid_a", W'(out_valid), W'(1'b0));
    step();
    check("postrst_valid_b", W'(out_valid), W'(1'b0));
    run_stream("len3", 6, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
